shape_sequencer: RTL and testbench

Upstream command stage for the `bresenham` line rasterizer. It accepts shape commands (line, triangle, rectangle, clear) into a small FIFO and breaks each shape into line segments. Segments are issued one at a time on the rasterizer's coordinate/start/done handshake. Coordinates are held stable for the whole life of each segment.

---
 rtl/shape_sequencer_if.sv | 44 ++++
 rtl/shape_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_shape_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shape_sequencer_if.sv
// rtl/shape_sequencer_if.sv - command and rasterizer handshake bundle for shape_sequencer
interface shape_sequencer_if #(
    parameter int COORD_W = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_op;
    logic [COORD_W-1:0] cmd_x0;
    logic [COORD_W-1:0] cmd_y0;
    logic [COORD_W-1:0] cmd_x1;
    logic [COORD_W-1:0] cmd_y1;
    logic [COORD_W-1:0] cmd_x2;
    logic [COORD_W-1:0] cmd_y2;

    logic [COORD_W-1:0] rast_x0;
    logic [COORD_W-1:0] rast_y0;
    logic [COORD_W-1:0] rast_x1;
    logic [COORD_W-1:0] rast_y1;
    logic               rast_start;
    logic               rast_reset_buff;
    logic               rast_done;

    logic               shape_done;
    logic               busy;
    logic               cmd_err;

    // Command source / rasterizer side
    modport master (
        output cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_x2, cmd_y2,
        output rast_done,
        input  cmd_ready,
        input  rast_x0, rast_y0, rast_x1, rast_y1, rast_start, rast_reset_buff,
        input  shape_done, busy, cmd_err
    );

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_x2, cmd_y2,
        input  rast_done,
        output cmd_ready,
        output rast_x0, rast_y0, rast_x1, rast_y1, rast_start, rast_reset_buff,
        output shape_done, busy, cmd_err
    );
endinterface

// File: rtl/shape_sequencer.sv
// rtl/shape_sequencer.sv - shape command FIFO and line-segment issuer for the rasterizer (option: SHAPE_SEQ_RECT_EN)
module shape_sequencer #(
    parameter int CMD_DEPTH = 4,
    parameter int COORD_W   = 8
) (
    input logic              clk,
    input logic              n_rst,
    shape_sequencer_if.slave bus
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] OP_LINE  = 2'd0;
    localparam logic [1:0] OP_TRI   = 2'd1;
    localparam logic [1:0] OP_RECT  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef struct packed {
        logic [1:0]         op;
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
        logic [COORD_W-1:0] x2;
        logic [COORD_W-1:0] y2;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_START,
        S_WAIT,
        S_GAP,
        S_CLR
    } state_t;

    cmd_t               fifo_q [CMD_DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [CW-1:0]      count_q;

    state_t             state_q;
    cmd_t               shape_q;
    logic [1:0]         seg_idx_q;
    logic [COORD_W-1:0] rast_x0_q;
    logic [COORD_W-1:0] rast_y0_q;
    logic [COORD_W-1:0] rast_x1_q;
    logic [COORD_W-1:0] rast_y1_q;
    logic               rast_start_q;
    logic               rast_reset_buff_q;
    logic               shape_done_q;
    logic               cmd_err_q;

    logic               full;
    logic               push;
    logic               pop;
    cmd_t               cmd_in;
    cmd_t               head;

    // Endpoints {x0,y0,x1,y1} of segment idx of shape c
    function automatic logic [4*COORD_W-1:0] seg_coords(input cmd_t c, input logic [1:0] idx);
        logic [4*COORD_W-1:0] r;
        r = {c.x0, c.y0, c.x1, c.y1};
        case (c.op)
            OP_TRI: begin
                case (idx)
                    2'd0:    r = {c.x0, c.y0, c.x1, c.y1};
                    2'd1:    r = {c.x1, c.y1, c.x2, c.y2};
                    default: r = {c.x2, c.y2, c.x0, c.y0};
                endcase
            end
`ifdef SHAPE_SEQ_RECT_EN
            OP_RECT: begin
                case (idx)
                    2'd0:    r = {c.x0, c.y0, c.x1, c.y0};
                    2'd1:    r = {c.x1, c.y0, c.x1, c.y1};
                    2'd2:    r = {c.x1, c.y1, c.x0, c.y1};
                    default: r = {c.x0, c.y1, c.x0, c.y0};
                endcase
            end
`endif
            default: r = {c.x0, c.y0, c.x1, c.y1};
        endcase
        return r;
    endfunction

    // Index of the final segment of an op
    function automatic logic [1:0] last_idx(input logic [1:0] op);
        case (op)
            OP_TRI:  return 2'd2;
            OP_RECT: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Whether an op may be issued in this build
    function automatic logic op_legal(input logic [1:0] op);
`ifdef SHAPE_SEQ_RECT_EN
        return (op == OP_LINE) || (op == OP_TRI) || (op == OP_RECT);
`else
        return (op == OP_LINE) || (op == OP_TRI);
`endif
    endfunction

    // Readiness comes only from the registered count, so a full FIFO never takes a push even while popping
    assign full  = (count_q == CW'(CMD_DEPTH));
    assign push  = bus.cmd_valid && bus.cmd_ready;
    assign pop   = (state_q == S_LOAD);
    assign head  = fifo_q[rd_ptr_q];
    assign cmd_in = '{op: bus.cmd_op, x0: bus.cmd_x0, y0: bus.cmd_y0, x1: bus.cmd_x1,
                      y1: bus.cmd_y1, x2: bus.cmd_x2, y2: bus.cmd_y2};

    assign bus.cmd_ready       = !full && !n_rst;
    assign bus.busy            = (state_q != S_IDLE) || (count_q != '0);
    assign bus.rast_x0         = rast_x0_q;
    assign bus.rast_y0         = rast_y0_q;
    assign bus.rast_x1         = rast_x1_q;
    assign bus.rast_y1         = rast_y1_q;
    assign bus.rast_start      = rast_start_q;
    assign bus.rast_reset_buff = rast_reset_buff_q;
    assign bus.shape_done      = shape_done_q;
    assign bus.cmd_err         = cmd_err_q;

    // Command storage; only written on an accepted push
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= cmd_in;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sequencer FSM with registered rasterizer outputs; pulses default low each cycle
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q           <= S_IDLE;
            shape_q           <= '0;
            seg_idx_q         <= 2'd0;
            rast_x0_q         <= '0;
            rast_y0_q         <= '0;
            rast_x1_q         <= '0;
            rast_y1_q         <= '0;
            rast_start_q      <= 1'b0;
            rast_reset_buff_q <= 1'b0;
            shape_done_q      <= 1'b0;
            cmd_err_q         <= 1'b0;
        end else begin
            rast_start_q      <= 1'b0;
            rast_reset_buff_q <= 1'b0;
            shape_done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    shape_q   <= head;
                    seg_idx_q <= 2'd0;
                    if (head.op == OP_CLEAR) begin
                        rast_reset_buff_q <= 1'b1;
                        shape_done_q      <= 1'b1;
                        state_q           <= S_CLR;
                    end else if (!op_legal(head.op)) begin
                        // Dropped without issuing segments; the head is popped this cycle
                        cmd_err_q    <= 1'b1;
                        shape_done_q <= 1'b1;
                        state_q      <= (count_q > CW'(1)) ? S_LOAD : S_IDLE;
                    end else begin
                        // Coordinates land as SETUP begins, a full cycle ahead of the start pulse
                        {rast_x0_q, rast_y0_q, rast_x1_q, rast_y1_q} <= seg_coords(head, 2'd0);
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    rast_start_q <= 1'b1;
                    state_q      <= S_START;
                end
                S_START: begin
                    // A done seen alongside the start pulse belongs to an older segment
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.rast_done) begin
                        if (seg_idx_q == last_idx(shape_q.op)) shape_done_q <= 1'b1;
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (seg_idx_q != last_idx(shape_q.op)) begin
                        seg_idx_q <= seg_idx_q + 2'd1;
                        {rast_x0_q, rast_y0_q, rast_x1_q, rast_y1_q} <= seg_coords(shape_q, seg_idx_q + 2'd1);
                        state_q <= S_SETUP;
                    end else begin
                        state_q <= (count_q != '0) ? S_LOAD : S_IDLE;
                    end
                end
                S_CLR: begin
                    state_q <= (count_q != '0) ? S_LOAD : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_shape_sequencer.sv
// tb/tb_shape_sequencer.sv - directed and randomized self-checking bench for shape_sequencer
module tb_shape_sequencer;
    localparam int CW = 8;
`ifdef SHAPE_SEQ_RECT_EN
    localparam bit RECT_EN = 1'b1;
`else
    localparam bit RECT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    shape_sequencer_if #(.COORD_W(CW)) bus();

    shape_sequencer #(.CMD_DEPTH(4), .COORD_W(CW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    bit          err_model   = 1'b0;
    logic [31:0] exp_q[$];
    logic [7:0]  lx0[6], ly0[6], lx1[6], ly1[6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rast_now();
        return {bus.rast_x0, bus.rast_y0, bus.rast_x1, bus.rast_y1};
    endfunction

    // Shape as a closed/open polyline of vertices; segment i joins vertex i to vertex i+1 (mod count)
    task automatic build_model(input logic [1:0] op, input logic [7:0] x0, y0, x1, y1, x2, y2);
        logic [7:0] vx[4];
        logic [7:0] vy[4];
        int nv, ns;
        exp_q.delete();
        vx[0] = x0; vy[0] = y0; vx[1] = x1; vy[1] = y1;
        vx[2] = x2; vy[2] = y2; vx[3] = 8'd0; vy[3] = 8'd0;
        case (op)
            2'd0: begin nv = 2; ns = 1; end
            2'd1: begin nv = 3; ns = 3; end
            2'd2: begin
                vx[1] = x1; vy[1] = y0; vx[2] = x1; vy[2] = y1; vx[3] = x0; vy[3] = y1;
                nv = 4; ns = RECT_EN ? 4 : 0;
            end
            default: begin nv = 1; ns = 0; end
        endcase
        for (int i = 0; i < ns; i++)
            exp_q.push_back({vx[i], vy[i], vx[(i + 1) % nv], vy[(i + 1) % nv]});
    endtask

    task automatic set_cmd(input logic [1:0] op, input logic [7:0] x0, y0, x1, y1, x2, y2);
        bus.cmd_op = op;
        bus.cmd_x0 = x0; bus.cmd_y0 = y0; bus.cmd_x1 = x1;
        bus.cmd_y1 = y1; bus.cmd_x2 = x2; bus.cmd_y2 = y2;
    endtask

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] x0, y0, x1, y1, x2, y2);
        int w = 0;
        while (!bus.cmd_ready && w < 20) begin tick(); w++; end
        if (w >= 20) chk("push ready timeout", 32'(w), 32'd0);
        set_cmd(op, x0, y0, x1, y1, x2, y2);
        bus.cmd_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic expect_start(input string tag, input int exp_lat, input logic [31:0] seg);
        int k = 0;
        do begin tick(); k++; end while (!bus.rast_start && k < 12);
        chk({tag, " start latency"}, 32'(k), 32'(exp_lat));
        chk({tag, " coords"}, rast_now(), seg);
    endtask

    task automatic finish_segment(input string tag, input int delay, input logic [31:0] seg, input bit last);
        for (int i = 0; i < delay; i++) begin
            tick();
            if (i == 0) chk({tag, " start one cycle"}, 32'(bus.rast_start), 32'd0);
        end
        chk({tag, " coords held"}, rast_now(), seg);
        bus.rast_done = 1'b1;
        tick();
        bus.rast_done = 1'b0;
        chk({tag, " shape_done"}, 32'(bus.shape_done), 32'(last));
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] x0, y0, x1, y1, x2, y2,
                           input int delay);
        int starts;
        build_model(op, x0, y0, x1, y1, x2, y2);
        push_cmd(op, x0, y0, x1, y1, x2, y2);
        if (op == 2'd3) begin
            tick(); tick();
            chk({tag, " reset_buff"}, 32'(bus.rast_reset_buff), 32'd1);
            chk({tag, " clr shape_done"}, 32'(bus.shape_done), 32'd1);
            tick();
            chk({tag, " reset_buff pulse"}, 32'(bus.rast_reset_buff), 32'd0);
            chk({tag, " busy after"}, 32'(bus.busy), 32'd0);
        end else if (exp_q.size() == 0) begin
            err_model = 1'b1;
            tick(); tick();
            chk({tag, " illegal shape_done"}, 32'(bus.shape_done), 32'd1);
            starts = 0;
            for (int i = 0; i < 5; i++) begin
                tick();
                starts += int'(bus.rast_start);
            end
            chk({tag, " illegal starts"}, 32'(starts), 32'd0);
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                expect_start(tag, (i == 0) ? 3 : 2, exp_q[i]);
                finish_segment(tag, delay, exp_q[i], i == exp_q.size() - 1);
            end
            tick();
            chk({tag, " busy after"}, 32'(bus.busy), 32'd0);
        end
        chk({tag, " cmd_err"}, 32'(bus.cmd_err), 32'(err_model));
    endtask

    initial begin
        int acc, seen;
        bit r;
        logic [7:0] t[6];

        n_rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.rast_done = 1'b0;
        set_cmd(2'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        tick(); tick(); tick();
        chk("reset cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("reset coords", rast_now(), 32'd0);
        chk("reset start", 32'(bus.rast_start), 32'd0);
        chk("reset reset_buff", 32'(bus.rast_reset_buff), 32'd0);
        chk("reset shape_done", 32'(bus.shape_done), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset cmd_err", 32'(bus.cmd_err), 32'd0);
        n_rst = 1'b0;
        tick();
        chk("post-reset cmd_ready", 32'(bus.cmd_ready), 32'd1);

        run_cmd("line", 2'd0, 8'd3, 8'd4, 8'd20, 8'd9, 8'd0, 8'd0, 10);
        run_cmd("tri", 2'd1, 8'd0, 8'd0, 8'd10, 8'd0, 8'd5, 8'd8, 2);
        run_cmd("rect", 2'd2, 8'd2, 8'd2, 8'd6, 8'd5, 8'd0, 8'd0, 1);
        run_cmd("zero-len", 2'd0, 8'd7, 8'd7, 8'd7, 8'd7, 8'd0, 8'd0, 1);

        // rast_done coinciding with the start pulse must not end the segment
        build_model(2'd0, 8'd1, 8'd2, 8'd30, 8'd40, 8'd0, 8'd0);
        push_cmd(2'd0, 8'd1, 8'd2, 8'd30, 8'd40, 8'd0, 8'd0);
        expect_start("done@start", 3, exp_q[0]);
        bus.rast_done = 1'b1;
        tick();
        bus.rast_done = 1'b0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen += int'(bus.rast_start) + int'(bus.shape_done);
        end
        chk("done@start ignored", 32'(seen), 32'd0);
        chk("done@start busy", 32'(bus.busy), 32'd1);
        finish_segment("done@start", 1, exp_q[0], 1'b1);
        tick();

        // CLEAR followed immediately by a LINE
        build_model(2'd0, 8'd11, 8'd12, 8'd13, 8'd14, 8'd0, 8'd0);
        set_cmd(2'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
        bus.cmd_valid = 1'b1;
        tick();
        set_cmd(2'd0, 8'd11, 8'd12, 8'd13, 8'd14, 8'd0, 8'd0);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("clr+line reset_buff", 32'(bus.rast_reset_buff), 32'd1);
        chk("clr+line shape_done", 32'(bus.shape_done), 32'd1);
        tick();
        chk("clr+line reset_buff pulse", 32'(bus.rast_reset_buff), 32'd0);
        tick();
        chk("clr+line setup coords", rast_now(), exp_q[0]);
        chk("clr+line setup start low", 32'(bus.rast_start), 32'd0);
        expect_start("clr+line", 1, exp_q[0]);
        finish_segment("clr+line", 1, exp_q[0], 1'b1);
        tick();

        // Fill the FIFO behind a stalled segment
        for (int j = 0; j < 6; j++) begin
            lx0[j] = 8'($urandom); ly0[j] = 8'($urandom);
            lx1[j] = 8'($urandom); ly1[j] = 8'($urandom);
        end
        acc = 0;
        set_cmd(2'd0, lx0[0], ly0[0], lx1[0], ly1[0], 8'd0, 8'd0);
        bus.cmd_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            r = bus.cmd_ready;
            tick();
            if (r) begin
                acc++;
                if (acc < 6) set_cmd(2'd0, lx0[acc], ly0[acc], lx1[acc], ly1[acc], 8'd0, 8'd0);
            end
        end
        chk("fill accepts", 32'(acc), 32'd5);
        chk("fill full ready", 32'(bus.cmd_ready), 32'd0);
        chk("fill L0 coords", rast_now(), {lx0[0], ly0[0], lx1[0], ly1[0]});
        bus.rast_done = 1'b1;
        tick();
        bus.rast_done = 1'b0;
        chk("fill L0 shape_done", 32'(bus.shape_done), 32'd1);
        chk("fill gap ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        chk("fill load ready", 32'(bus.cmd_ready), 32'd0);
        tick();
        chk("fill after-load ready", 32'(bus.cmd_ready), 32'd1);
        chk("fill L1 setup coords", rast_now(), {lx0[1], ly0[1], lx1[1], ly1[1]});
        tick();
        bus.cmd_valid = 1'b0;
        chk("fill L1 start", 32'(bus.rast_start), 32'd1);
        finish_segment("fill L1", 2, {lx0[1], ly0[1], lx1[1], ly1[1]}, 1'b1);
        for (int j = 2; j < 6; j++) begin
            expect_start("fill back2back", 3, {lx0[j], ly0[j], lx1[j], ly1[j]});
            finish_segment("fill back2back", 1, {lx0[j], ly0[j], lx1[j], ly1[j]}, 1'b1);
        end
        tick();
        chk("fill drained busy", 32'(bus.busy), 32'd0);

        // Randomized commands into an idle block
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 6; i++) t[i] = 8'($urandom);
            run_cmd("random", 2'($urandom_range(0, 3)), t[0], t[1], t[2], t[3], t[4], t[5],
                    int'($urandom_range(1, 6)));
        end

        // Reset during the last TRI segment with another command queued
        for (int i = 0; i < 6; i++) t[i] = 8'($urandom);
        build_model(2'd1, t[0], t[1], t[2], t[3], t[4], t[5]);
        push_cmd(2'd1, t[0], t[1], t[2], t[3], t[4], t[5]);
        expect_start("rst tri", 3, exp_q[0]);
        finish_segment("rst tri", 1, exp_q[0], 1'b0);
        expect_start("rst tri", 2, exp_q[1]);
        finish_segment("rst tri", 1, exp_q[1], 1'b0);
        expect_start("rst tri", 2, exp_q[2]);
        tick();
        push_cmd(2'd0, 8'd9, 8'd9, 8'd1, 8'd1, 8'd0, 8'd0);
        n_rst = 1'b1;
        tick();
        err_model = 1'b0;
        chk("midrst coords", rast_now(), 32'd0);
        chk("midrst start", 32'(bus.rast_start), 32'd0);
        chk("midrst reset_buff", 32'(bus.rast_reset_buff), 32'd0);
        chk("midrst shape_done", 32'(bus.shape_done), 32'd0);
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst cmd_err", 32'(bus.cmd_err), 32'd0);
        chk("midrst cmd_ready", 32'(bus.cmd_ready), 32'd0);
        n_rst = 1'b0;
        bus.rast_done = 1'b1;
        tick();
        bus.rast_done = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen += int'(bus.rast_start) + int'(bus.shape_done) + int'(bus.busy);
        end
        chk("midrst stray done ignored", 32'(seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
